// File: rtl/speck_pkg.sv
// Shared SPECK128/128 constants and FSM encodings, used by the encryption
// datapath and by the encrypt/decrypt key schedules.
package speck_pkg;

    localparam int WORD   = 64;
    localparam int ROUNDS = 32;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_RUN  = 4'd1;
    localparam logic [3:0] ST_DONE = 4'd2;

    typedef enum logic [3:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/speck_encrypt_datapath_round.sv
// One SPECK round: x' = (ROR(x,ALPHA) + y) ^ k, y' = ROL(y,BETA) ^ x'.
// Purely combinational; the key schedule reuses it with k = round index.
module speck_round #(
    parameter int WORD = speck_pkg::WORD
) (
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic [WORD-1:0] k,
    output logic [WORD-1:0] x_next,
    output logic [WORD-1:0] y_next
);
    import speck_pkg::*;

    logic [WORD-1:0] x_ror;
    logic [WORD-1:0] y_rol;

    assign x_ror  = {x[ALPHA-1:0], x[WORD-1:ALPHA]};
    assign y_rol  = {y[WORD-1-BETA:0], y[WORD-1:WORD-BETA]};
    // Add wraps modulo 2^WORD; the carry-out is deliberately dropped.
    assign x_next = (x_ror + y) ^ k;
    assign y_next = y_rol ^ x_next;

endmodule

// File: rtl/speck_encrypt_datapath.sv
// Iterative SPECK128/128 encryption: latches plaintext on start, applies one
// round per accepted round key, then presents the ciphertext for one DONE cycle.
module speck_encrypt_datapath #(
    parameter int ROUNDS = speck_pkg::ROUNDS,
    parameter int WORD   = speck_pkg::WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              signal_start,
    input  logic [2*WORD-1:0] plaintext,
    input  logic [WORD-1:0]   round_key,
    input  logic              rk_valid,
    output logic              rk_ready,
    output logic [2*WORD-1:0] ciphertext,
    output logic              finished,
    output logic [3:0]        state_response
);
    import speck_pkg::*;

    localparam int               RND_W    = $clog2(ROUNDS);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [RND_W-1:0] rnd;
    logic [WORD-1:0]  x;
    logic [WORD-1:0]  y;
    logic [WORD-1:0]  x_nx;
    logic [WORD-1:0]  y_nx;
    logic             accept;
    logic             last;

    speck_round #(.WORD(WORD)) u_round (
        .x      (x),
        .y      (y),
        .k      (round_key),
        .x_next (x_nx),
        .y_next (y_nx)
    );

    assign accept = (state_q == RUN) && rk_valid;
    assign last   = accept && (rnd == LAST_RND);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (signal_start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd        <= '0;
            x          <= '0;
            y          <= '0;
            ciphertext <= '0;
        end else if (state_q == IDLE && signal_start) begin
            rnd <= '0;
            x   <= plaintext[2*WORD-1:WORD];
            y   <= plaintext[WORD-1:0];
        end else if (accept) begin
            rnd <= rnd + 1'b1;
            x   <= x_nx;
            y   <= y_nx;
            // Only the final round's result is exposed, so the output never shows intermediates.
            if (last) ciphertext <= {x_nx, y_nx};
        end
    end

    // Handshake and status are pure decodes of the state register.
    assign rk_ready       = (state_q == RUN);
    assign finished       = (state_q == DONE);
    assign state_response = state_q;

endmodule

// File: tb/tb_speck_encrypt_datapath.sv
// Directed + randomized bench for speck_encrypt_datapath against a
// word-level SPECK128/128 reference model (key schedule + encryption).
module tb_speck_encrypt_datapath;

    localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] STD_PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] STD_CT  = 128'ha65d985179783265_7860fedf5c570d18;

    logic         clk;
    logic         rst_n;
    logic         signal_start;
    logic [127:0] plaintext;
    logic [63:0]  round_key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] ciphertext;
    logic         finished;
    logic [3:0]   state_response;

    int           n_cmp;
    int           n_fail;
    logic [63:0]  rk_tab [32];
    logic [127:0] last_ct;

    speck_encrypt_datapath dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .signal_start   (signal_start),
        .plaintext      (plaintext),
        .round_key      (round_key),
        .rk_valid       (rk_valid),
        .rk_ready       (rk_ready),
        .ciphertext     (ciphertext),
        .finished       (finished),
        .state_response (state_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic logic [63:0] rol64(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    task automatic key_schedule(input logic [127:0] key);
        logic [63:0] k;
        logic [63:0] l;
        k = key[63:0];
        l = key[127:64];
        for (int i = 0; i < 32; i++) begin
            rk_tab[i] = k;
            l = (ror64(l, 8) + k) ^ 64'(i);
            k = rol64(k, 3) ^ l;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [63:0] x;
        logic [63:0] y;
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 32; i++) begin
            x = (ror64(x, 8) + y) ^ rk_tab[i];
            y = rol64(y, 3) ^ x;
        end
        return {x, y};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one encryption; cycle numbering counts the start edge as cycle 1.
    task automatic run_enc(input logic [127:0] pt, input bit stall, input int start_again,
                           input int abort_at, output logic [127:0] ct, output int fin_cyc,
                           output int fin_cnt, output bit aborted);
        int  idx;
        int  cyc;
        bit  acc;
        bit  hold_checked;
        idx = 0;
        fin_cyc = -1;
        fin_cnt = 0;
        aborted = 1'b0;
        hold_checked = 1'b0;
        ct = '0;
        @(negedge clk);
        plaintext    = pt;
        signal_start = 1'b1;
        @(negedge clk);
        signal_start = 1'b0;
        plaintext    = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        check("rdy_after_start", 128'(rk_ready), 128'(1));
        for (int n = 0; n < 200; n++) begin
            if (finished) begin
                fin_cnt++;
                if (fin_cyc < 0) begin
                    fin_cyc = cyc;
                    ct = ciphertext;
                    check("rdy_in_done", 128'(rk_ready), 128'(0));
                    check("state_done", 128'(state_response), 128'(2));
                end
            end
            if (fin_cyc >= 0 && cyc == fin_cyc + 1)
                check("state_idle_after", 128'(state_response), 128'(0));
            if (fin_cyc >= 0 && cyc >= fin_cyc + 3) break;
            if (idx == abort_at) begin
                aborted = 1'b1;
                return;
            end
            if (idx == 16 && !hold_checked) begin
                hold_checked = 1'b1;
                check("ct_hold_midrun", ciphertext, last_ct);
            end
            rk_valid     = !(stall && (cyc % 2 == 0) && cyc <= 32);
            round_key    = (idx < 32) ? rk_tab[idx] : {$urandom, $urandom};
            signal_start = (idx == start_again && start_again >= 0);
            acc = rk_valid && rk_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        signal_start = 1'b0;
        rk_valid     = 1'b0;
        check("ct_hold_idle", ciphertext, ct);
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] exp_ct;
        int           fin_cyc;
        int           fin_cnt;
        bit           aborted;

        n_cmp        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        signal_start = 1'b0;
        plaintext    = '0;
        round_key    = '0;
        rk_valid     = 1'b0;
        last_ct      = '0;

        repeat (3) @(negedge clk);
        check("rst_ct", ciphertext, 128'(0));
        check("rst_state", 128'(state_response), 128'(0));
        check("rst_rdy", 128'(rk_ready), 128'(0));
        check("rst_fin", 128'(finished), 128'(0));
        rst_n = 1'b1;

        // Keys offered in IDLE must not be taken.
        rk_valid  = 1'b1;
        round_key = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        check("idle_rdy", 128'(rk_ready), 128'(0));
        check("idle_state", 128'(state_response), 128'(0));
        check("idle_ct", ciphertext, 128'(0));
        rk_valid = 1'b0;

        key_schedule(STD_KEY);
        check("k0_model_sanity", 128'(rk_tab[0]), 128'(64'h0706050403020100));

        run_enc(STD_PT, 1'b0, -1, -1, ct, fin_cyc, fin_cnt, aborted);
        check("std_ct", ct, STD_CT);
        check("std_latency", 128'(fin_cyc), 128'(33));
        check("std_fin_cnt", 128'(fin_cnt), 128'(1));
        last_ct = STD_CT;

        run_enc(STD_PT, 1'b1, -1, -1, ct, fin_cyc, fin_cnt, aborted);
        check("stall_ct", ct, STD_CT);
        check("stall_latency", 128'(fin_cyc), 128'(49));

        run_enc(STD_PT, 1'b0, 10, -1, ct, fin_cyc, fin_cnt, aborted);
        check("restart_ct", ct, STD_CT);
        check("restart_fin_cnt", 128'(fin_cnt), 128'(1));
        check("restart_latency", 128'(fin_cyc), 128'(33));

        // Abort at round 20 by reset, then rerun the standard vector.
        run_enc(STD_PT, 1'b0, -1, 20, ct, fin_cyc, fin_cnt, aborted);
        check("abort_reached", 128'(aborted), 128'(1));
        rst_n    = 1'b0;
        rk_valid = 1'b0;
        #1;
        check("abort_ct", ciphertext, 128'(0));
        check("abort_state", 128'(state_response), 128'(0));
        check("abort_rdy", 128'(rk_ready), 128'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        last_ct = '0;
        run_enc(STD_PT, 1'b0, -1, -1, ct, fin_cyc, fin_cnt, aborted);
        check("rerun_ct", ct, STD_CT);
        check("rerun_latency", 128'(fin_cyc), 128'(33));
        last_ct = STD_CT;

        key_schedule(128'(0));
        exp_ct = ref_encrypt(128'(0));
        run_enc(128'(0), 1'b0, -1, -1, ct, fin_cyc, fin_cnt, aborted);
        check("zero_ct", ct, exp_ct);
        last_ct = exp_ct;

        key_schedule({$urandom, $urandom, $urandom, $urandom});
        pt = {64'hffffffffffffffff, $urandom, $urandom};
        exp_ct = ref_encrypt(pt);
        run_enc(pt, 1'b0, -1, -1, ct, fin_cyc, fin_cnt, aborted);
        check("wrap_ct", ct, exp_ct);
        last_ct = exp_ct;

        for (int t = 0; t < 4; t++) begin
            key_schedule({$urandom, $urandom, $urandom, $urandom});
            pt = {$urandom, $urandom, $urandom, $urandom};
            exp_ct = ref_encrypt(pt);
            run_enc(pt, t[0], -1, -1, ct, fin_cyc, fin_cnt, aborted);
            check("rand_ct", ct, exp_ct);
            check("rand_fin_cnt", 128'(fin_cnt), 128'(1));
            last_ct = exp_ct;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/speck_encrypt_datapath.md
# speck_encrypt_datapath

Iterative SPECK128/128 encryption datapath that sits directly downstream of the encryption key schedule. It latches a 128-bit plaintext block on a start pulse and consumes one 64-bit round key per round over a valid/ready handshake. It applies the 32 SPECK rounds one per accepted key, then presents the 128-bit ciphertext with a one-cycle finished pulse.

## Interface
- ROUNDS, 32: number of rounds; fixed by SPECK128/128.
- WORD, 64: word width n; the block is 2·WORD wide.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- signal_start  in  1  one-cycle start pulse; sampled only in IDLE.
- plaintext  in  128  block input; [127:64] = x, [63:0] = y; latched on accepted start.
- round_key  in  64  round key k_i from the key schedule.
- rk_valid  in  1  round_key is valid this cycle.
- rk_ready  out  1  datapath accepts a round key this cycle.
- ciphertext  out  128  result; [127:64] = x, [63:0] = y.
- finished  out  1  one-cycle pulse when ciphertext becomes valid.
- state_response  out  4  current FSM state encoding, for debug.

## Operation
- FSM states: IDLE=4'd0, RUN=4'd1, DONE=4'd2. All other codes are illegal and go to IDLE.
- IDLE: rk_ready=0. On signal_start=1, latch plaintext into x/y, clear round counter rnd to 0, and go to RUN.
- RUN: rk_ready=1. Each cycle with rk_valid&&rk_ready applies one round:
  - x' = (ROR(x,8) + y) mod 2^64 XOR k
  - y' = ROL(y,3) XOR x'
  - rnd increments. Cycles with rk_valid=0 stall with no state change.
- When the round with rnd==ROUNDS-1 is accepted, the result is written to x/y and the FSM goes to DONE.
- DONE, one cycle: finished=1, rk_ready=0, ciphertext={x,y}. Return to IDLE on the next cycle.
- ciphertext is registered. It updates only on entry to DONE and holds until the next completed encryption. It does not show intermediate round values.
- Arithmetic: the 64-bit add wraps with no carry-out. Rotations are fixed wiring.
- signal_start in RUN or DONE is ignored; no restart and no queuing.
- rk_valid in IDLE or DONE is not accepted. The upstream holds the key until rk_ready.
- rnd is 5 bits and never wraps past 31 in RUN, because the FSM leaves RUN on round 31.

## Timing
- Reset values: state=IDLE, rnd=0, x=y=0, ciphertext=0, finished=0, rk_ready=0, state_response=0.
- Reset asserted mid-encryption aborts immediately. Outputs return to reset values and the partial result is discarded.
- Start pulse at edge t puts the FSM in RUN from t+1, so rk_ready=1 in cycle t+1.
- With rk_valid held high, the 32 rounds are accepted in cycles t+1…t+32. DONE and finished=1 occur in cycle t+33. IDLE is reached at t+34.
- Minimum start-to-finished latency is 33 cycles. Each stall cycle adds exactly one.
- A new signal_start is accepted in the IDLE cycle at t+34 at the earliest.
- No combinational path from rk_valid to rk_ready. rk_ready is a decode of the state register.

## Structure
- Package speck_pkg holds:
  - WORD=64, ROUNDS=32, ALPHA=8, BETA=3
  - state encodings IDLE/RUN/DONE as 4-bit localparams
  - shared with key_schedule_encrypt/decrypt, which use the same ALPHA/BETA.
- Sub-module speck_round: purely combinational, inputs x, y, k and outputs x', y'. The same round function is reused by the key schedule with k = round index.
- Top level holds the FSM, the round counter, the x/y registers and the ciphertext register.

## Test plan
- Standard vector: key 0f0e0d0c0b0a0908_0706050403020100, with the bench supplying round keys from a reference model (k0=0706050403020100). Plaintext 6c61766975716520_7469206564616d20 -> ciphertext a65d985179783265_7860fedf5c570d18, finished high exactly in cycle t+33.
- Same vector with rk_valid deasserted every other cycle -> identical ciphertext; finished at t+33+16 for 16 stall cycles.
- signal_start pulsed again during RUN (round 10) -> ignored; the result still equals the standard vector and there is exactly one finished pulse.
- rst_n asserted at round 20, then released, then the standard vector rerun -> ciphertext=0 and state_response=0 during reset; the rerun result is correct.
- rk_valid=1 while in IDLE and DONE -> rk_ready=0 and x/y unchanged; ciphertext holds its previous value until the next DONE.
- All-zero key schedule and plaintext 0 -> ciphertext matches the reference model; the add wrap is checked with x=ffffffffffffffff injected via plaintext.
